// File: rtl/logit_argmax_rx.sv
// Frame receiver for classifier logits: buffers one frame, tracks top-1/top-2
// on the fly and hands the argmax, score, margin and detect flag to the host.
module logit_argmax_rx #(
    parameter int NUM_CLASSES = 20,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] threshold,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ADDR_W-1:0] class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic [DATA_W-1:0] margin,
    output logic              detect,
    output logic              err_seq,
    output logic              err_overrun,
    output logic              busy,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);
    localparam logic [ADDR_W:0]   NCLS      = (ADDR_W + 1)'(NUM_CLASSES);
    localparam logic [DATA_W-1:0] SMIN      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] SMAX      = {1'b0, {(DATA_W-1){1'b1}}};

    state_e                         state_q, state_d;
    logic [ADDR_W-1:0]              expected_q, expected_d;
    logic [DATA_W-1:0]              best_q, best_d, second_q, second_d;
    logic [ADDR_W-1:0]              best_idx_q, best_idx_d;
    logic [ADDR_W-1:0]              class_idx_q, class_idx_d;
    logic [DATA_W-1:0]              class_score_q, class_score_d;
    logic [DATA_W-1:0]              margin_q, margin_d;
    logic                           detect_q, detect_d;
    logic                           err_seq_q, err_seq_d;
    logic                           err_ovr_q, err_ovr_d;
    logic [NUM_CLASSES-1:0][DATA_W-1:0] buf_q;
    logic                           buf_we;
    logic                           start, accept;
    logic [DATA_W:0]                diff;

    always_comb begin
        state_d       = state_q;
        expected_d    = expected_q;
        best_d        = best_q;
        second_d      = second_q;
        best_idx_d    = best_idx_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        margin_d      = margin_q;
        detect_d      = detect_q;
        err_seq_d     = 1'b0;
        err_ovr_d     = 1'b0;
        buf_we        = 1'b0;
        start         = 1'b0;
        accept        = 1'b0;
        diff          = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_addr == '0) start = 1'b1;
                    else               err_seq_d = 1'b1;
                end
            end
            COLLECT: begin
                // expected is never 0 here, so an addr-0 mismatch is a restart
                if (in_valid) begin
                    if (in_addr == expected_q) begin
                        accept = 1'b1;
                    end else if (in_addr == '0) begin
                        err_seq_d = 1'b1;
                        start     = 1'b1;
                    end else begin
                        err_seq_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            HOLD: begin
                if (result_ready) begin
                    if (!in_valid) begin
                        state_d = IDLE;
                    end else if (in_addr == '0) begin
                        start = 1'b1;
                    end else begin
                        err_seq_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (in_valid) begin
                    err_ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            buf_we     = 1'b1;
            best_d     = in_data;
            second_d   = SMIN;
            best_idx_d = '0;
            expected_d = ADDR_W'(1);
            state_d    = COLLECT;
        end

        if (accept) begin
            buf_we     = 1'b1;
            expected_d = expected_q + 1'b1;
            // strict compares keep the lower index on ties
            if ($signed(in_data) > $signed(best_q)) begin
                second_d   = best_q;
                best_d     = in_data;
                best_idx_d = in_addr;
            end else if ($signed(in_data) > $signed(second_q)) begin
                second_d = in_data;
            end
            if (in_addr == LAST_ADDR) begin
                // best >= second always holds, so only overflow above SMAX matters
                diff          = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};
                margin_d      = (diff[DATA_W] || diff[DATA_W-1]) ? SMAX : diff[DATA_W-1:0];
                class_idx_d   = best_idx_d;
                class_score_d = best_d;
                detect_d      = $signed(margin_d) >= $signed(threshold);
                state_d       = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            expected_q    <= '0;
            best_q        <= '0;
            second_q      <= '0;
            best_idx_q    <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            margin_q      <= '0;
            detect_q      <= 1'b0;
            err_seq_q     <= 1'b0;
            err_ovr_q     <= 1'b0;
            buf_q         <= '0;
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            best_q        <= best_d;
            second_q      <= second_d;
            best_idx_q    <= best_idx_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            margin_q      <= margin_d;
            detect_q      <= detect_d;
            err_seq_q     <= err_seq_d;
            err_ovr_q     <= err_ovr_d;
            if (buf_we) buf_q[in_addr] <= in_data;
        end
    end

    assign result_valid = (state_q == HOLD);
    assign busy         = (state_q == COLLECT);
    assign class_idx    = class_idx_q;
    assign class_score  = class_score_q;
    assign margin       = margin_q;
    assign detect       = detect_q;
    assign err_seq      = err_seq_q;
    assign err_overrun  = err_ovr_q;
    assign rd_data      = ({1'b0, rd_addr} < NCLS) ? buf_q[rd_addr] : '0;

endmodule

// File: tb/tb_logit_argmax_rx.sv
// Directed bench for logit_argmax_rx: a frame-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_logit_argmax_rx;
    localparam int N = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [4:0]  in_addr = '0;
    logic        in_valid = 1'b0;
    logic [31:0] threshold = '0;
    logic        result_valid, result_ready = 1'b0;
    logic [4:0]  class_idx;
    logic [31:0] class_score, margin;
    logic        detect, err_seq, err_overrun, busy;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    logit_argmax_rx #(.NUM_CLASSES(N), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_addr(in_addr), .in_valid(in_valid),
        .threshold(threshold), .result_valid(result_valid), .result_ready(result_ready),
        .class_idx(class_idx), .class_score(class_score), .margin(margin), .detect(detect),
        .err_seq(err_seq), .err_overrun(err_overrun), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pos = -1 idle, 0..N-1 next expected address, N result held
    int          pos = -1;
    bit          armed = 0;
    logic [31:0] mbuf [N];
    logic [4:0]  m_idx = '0;
    logic [31:0] m_score = '0, m_margin = '0;
    logic        m_det = 1'b0, m_seq = 1'b0, m_ovr = 1'b0;
    int          rda = 0;
    logic [31:0] fv [N];

    task automatic form_result(input logic [31:0] thr);
        int     bi;
        longint b, s, m, t;
        bi = 0;
        for (int i = 1; i < N; i++)
            if ($signed(mbuf[i]) > $signed(mbuf[bi])) bi = i;
        s = -64'sd2147483648;
        for (int i = 0; i < N; i++)
            if (i != bi && longint'($signed(mbuf[i])) > s) s = longint'($signed(mbuf[i]));
        b = longint'($signed(mbuf[bi]));
        t = longint'($signed(thr));
        m = b - s;
        if (m > 64'sd2147483647) m = 64'sd2147483647;
        m_idx    = 5'(bi);
        m_score  = mbuf[bi];
        m_margin = m[31:0];
        m_det    = (m >= t);
    endtask

    task automatic model_edge();
        m_seq = 1'b0;
        m_ovr = 1'b0;
        if (rst) begin
            pos = -1;
            for (int i = 0; i < N; i++) mbuf[i] = '0;
            m_idx = '0; m_score = '0; m_margin = '0; m_det = 1'b0;
        end else if (pos < 0) begin
            if (in_valid) begin
                if (in_addr == 0) begin mbuf[0] = in_data; pos = 1; end
                else m_seq = 1'b1;
            end
        end else if (pos < N) begin
            if (in_valid) begin
                if (int'(in_addr) == pos) begin
                    mbuf[pos] = in_data;
                    pos++;
                    if (pos == N) form_result(threshold);
                end else if (in_addr == 0) begin
                    m_seq = 1'b1; mbuf[0] = in_data; pos = 1;
                end else begin
                    m_seq = 1'b1; pos = -1;
                end
            end
        end else begin
            if (result_ready) begin
                if (!in_valid) pos = -1;
                else if (in_addr == 0) begin mbuf[0] = in_data; pos = 1; end
                else begin m_seq = 1'b1; pos = -1; end
            end else if (in_valid) begin
                m_ovr = 1'b1;
            end
        end
    endtask

    task automatic step(input bit v, input int a, input logic [31:0] d, input bit rdy);
        in_valid     = v;
        in_addr      = a[4:0];
        in_data      = d;
        result_ready = rdy;
        rd_addr      = rda[4:0];
        rda          = (rda + 7) % 26;
        @(posedge clk);
        model_edge();
        armed = 1;
        #1;
    endtask

    task automatic send_frame(input bit rdy);
        for (int i = 0; i < N; i++) step(1'b1, i, fv[i], rdy);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("result_valid", {31'b0, result_valid}, {31'b0, pos == N});
            chk("busy", {31'b0, busy}, {31'b0, pos >= 0 && pos < N});
            chk("err_seq", {31'b0, err_seq}, {31'b0, m_seq});
            chk("err_overrun", {31'b0, err_overrun}, {31'b0, m_ovr});
            chk("rd_data", rd_data, (rd_addr < N) ? mbuf[rd_addr] : 32'h0);
            if (pos == N) begin
                chk("class_idx", {27'b0, class_idx}, {27'b0, m_idx});
                chk("class_score", class_score, m_score);
                chk("margin", margin, m_margin);
                chk("detect", {31'b0, detect}, {31'b0, m_det});
            end
        end
    end

    task automatic load_frame1();
        for (int i = 0; i < N; i++) fv[i] = 32'hFF00_0000;
        fv[7] = 32'h0028_0000;
        fv[3] = 32'h0000_0000;
    endtask

    task automatic check_all_zero(input string tag);
        rd_addr = 5'd0;
        #1;
        chk({tag, "_rv"}, {31'b0, result_valid}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_idx"}, {27'b0, class_idx}, 32'd0);
        chk({tag, "_score"}, class_score, 32'd0);
        chk({tag, "_margin"}, margin, 32'd0);
        chk({tag, "_detect"}, {31'b0, detect}, 32'd0);
        chk({tag, "_errs"}, {30'b0, err_seq, err_overrun}, 32'd0);
        chk({tag, "_rd"}, rd_data, 32'd0);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        check_all_zero("reset");

        // main case: argmax at 7, second best 0.0 at 3
        threshold = 32'h0010_0000;
        load_frame1();
        send_frame(1'b1);
        chk("f1_rv", {31'b0, result_valid}, 32'd1);
        chk("f1_idx", {27'b0, class_idx}, 32'd7);
        chk("f1_score", class_score, 32'h0028_0000);
        chk("f1_margin", margin, 32'h0028_0000);
        chk("f1_detect", {31'b0, detect}, 32'd1);
        step(0, 0, 0, 1);
        chk("f1_done_rv", {31'b0, result_valid}, 32'd0);
        chk("f1_done_busy", {31'b0, busy}, 32'd0);

        // tie at 4 and 12: lower index wins, margin 0
        for (int i = 0; i < N; i++) fv[i] = 32'h0;
        fv[4] = 32'h0100_0000;
        fv[12] = 32'h0100_0000;
        threshold = 32'h0;
        send_frame(1'b1);
        chk("tie_idx", {27'b0, class_idx}, 32'd4);
        chk("tie_margin", margin, 32'h0);
        chk("tie_detect_thr0", {31'b0, detect}, 32'd1);
        step(0, 0, 0, 1);
        threshold = 32'h1;
        send_frame(1'b1);
        chk("tie_detect_thr1", {31'b0, detect}, 32'd0);
        step(0, 0, 0, 1);

        // skipped address 5
        load_frame1();
        for (int i = 0; i < 5; i++) step(1, i, fv[i], 1);
        step(1, 6, fv[6], 1);
        chk("skip_err_seq", {31'b0, err_seq}, 32'd1);
        chk("skip_busy", {31'b0, busy}, 32'd0);
        step(0, 0, 0, 1);
        chk("skip_rv", {31'b0, result_valid}, 32'd0);
        step(1, 3, 32'h1234_5678, 1);
        chk("idle_addr3_err", {31'b0, err_seq}, 32'd1);
        chk("idle_addr3_busy", {31'b0, busy}, 32'd0);

        // restart in the middle of a frame via addr 0
        step(1, 0, fv[0], 1);
        step(1, 1, fv[1], 1);
        step(1, 2, fv[2], 1);
        step(1, 0, fv[0], 1);
        chk("restart_err", {31'b0, err_seq}, 32'd1);
        chk("restart_busy", {31'b0, busy}, 32'd1);
        for (int i = 1; i < N; i++) step(1, i, fv[i], 1);
        chk("restart_idx", {27'b0, class_idx}, 32'd7);
        step(0, 0, 0, 1);

        // overrun while holding, then back-to-back start
        threshold = 32'h0010_0000;
        for (int i = 0; i < N; i++) fv[i] = 32'((i + 1) * 32'h0001_0000);
        send_frame(1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1, k, 32'hDEAD_BEEF, 0);
            chk("ovr_pulse", {31'b0, err_overrun}, 32'd1);
            chk("ovr_idx", {27'b0, class_idx}, 32'd19);
            chk("ovr_margin", margin, 32'h0001_0000);
        end
        step(0, 0, 0, 0);
        chk("ovr_pulse_end", {31'b0, err_overrun}, 32'd0);
        rd_addr = 5'd0;
        #1;
        chk("ovr_rd0", rd_data, 32'h0001_0000);
        step(1, 0, 32'h7FFF_FFFF, 1);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_rv", {31'b0, result_valid}, 32'd0);
        for (int i = 1; i < N; i++) step(1, i, 32'h8000_0000, 1);
        chk("sat_margin", margin, 32'h7FFF_FFFF);
        chk("sat_idx", {27'b0, class_idx}, 32'd0);
        chk("sat_score", class_score, 32'h7FFF_FFFF);
        chk("sat_detect", {31'b0, detect}, 32'd1);
        rd_addr = 5'd19;
        #1;
        chk("rd19", rd_data, 32'h8000_0000);
        rd_addr = 5'd25;
        #1;
        chk("rd25", rd_data, 32'h0);
        step(0, 0, 0, 1);

        // reset mid-frame, then in HOLD
        load_frame1();
        for (int i = 0; i <= 10; i++) step(1, i, fv[i], 1);
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        check_all_zero("rst_mid");
        send_frame(1'b0);
        chk("pre_rst_rv", {31'b0, result_valid}, 32'd1);
        rst = 1'b1;
        step(1, 0, 32'h0100_0000, 1);
        rst = 1'b0;
        check_all_zero("rst_hold");
        send_frame(1'b1);
        chk("post_rst_idx", {27'b0, class_idx}, 32'd7);
        chk("post_rst_margin", margin, 32'h0028_0000);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/logit_argmax_rx.md
# logit_argmax_rx

Receiver for the classifier logit stream emitted by the linear layer (32-bit signed Q7.24 value, 5-bit class address, valid strobe, 20 classes per frame). It buffers one frame, tracks the top-1 and top-2 scores on the fly, and presents the winning keyword class, its score and its top-1/top-2 margin through a valid/ready result handshake. It also raises a threshold-based detect flag and flags sequencing errors. It sits between the linear layer and the host-visible result registers.

## Interface
- NUM_CLASSES, 20, logits per frame (2..32)
- DATA_W, 32, logit width, signed Q7.24
- ADDR_W, 5, class address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  DATA_W  logit value (signed)
- in_addr  in  ADDR_W  class index of in_data
- in_valid  in  1  one logit per cycle when high; no backpressure
- threshold  in  DATA_W  signed detect margin threshold, sampled when the result is formed
- result_valid  out  1  result fields valid
- result_ready  in  1  consumer accepts result
- class_idx  out  ADDR_W  argmax class
- class_score  out  DATA_W  logit of class_idx
- margin  out  DATA_W  best minus second-best, saturated
- detect  out  1  margin >= threshold
- err_seq  out  1  one-cycle pulse: out-of-order or out-of-range address
- err_overrun  out  1  one-cycle pulse: logit dropped while holding a result
- busy  out  1  high in COLLECT
- rd_addr  in  ADDR_W  logit buffer read address
- rd_data  out  DATA_W  combinational buffer read; 0 if rd_addr >= NUM_CLASSES

## Operation
- States:
  - IDLE: waiting for a frame.
  - COLLECT: receiving a frame. Tracks `expected`, the next class address.
  - HOLD: result_valid high.
- IDLE:
  - in_valid with in_addr==0: store the logit, best=in_data, best_idx=0, second=0x80000000, expected=1, go to COLLECT.
  - Any other in_valid: err_seq pulse, logit dropped.
- COLLECT:
  - in_valid with in_addr==expected: buffer[in_addr]=in_data and update the tracker.
    - If in_data > best (strict signed): second=best, best=in_data, best_idx=in_addr.
    - Else if in_data > second: second=in_data.
    - Ties keep the lower index.
  - When in_addr==NUM_CLASSES-1 is accepted: latch class_idx, class_score, margin and detect from the updated tracker, and go to HOLD.
  - in_valid with in_addr==0: err_seq pulse, restart the frame with this logit as element 0.
  - Any other mismatch (including in_addr>=NUM_CLASSES): err_seq pulse, discard the frame, go to IDLE.
  - No in_valid: hold state; there is no timeout.
- HOLD:
  - Result fields are stable until result_valid && result_ready.
  - Handshake without in_valid: go to IDLE.
  - Handshake in the same cycle as in_valid with in_addr==0: complete the handshake and start a new frame, as in IDLE (back-to-back frames).
  - in_valid without a completed handshake: err_overrun pulse, logit dropped, buffer untouched.
  - in_valid with a completed handshake but in_addr!=0: err_seq pulse, go to IDLE.
- Arithmetic:
  - margin = best − second, computed in DATA_W+1 bits and saturated to 0x7FFFFFFF.
  - detect = signed(margin) >= signed(threshold), with threshold sampled in the latch cycle.
- Buffer: NUM_CLASSES×DATA_W registers, written only on accepted logits. rd_data reflects the last accepted frame, including a partial one.

## Timing
- Reset (rst high at a rising edge):
  - State goes to IDLE.
  - result_valid, busy, detect, err_seq and err_overrun go to 0.
  - class_idx, class_score, margin and the buffer go to 0.
  - A partial frame or pending result is discarded.
  - Reset takes priority over all events in the same cycle.
- Accept of the final logit at edge T: result_valid=1 and all fields valid after T, i.e. visible in cycle T+1. Result latency is 1 cycle from the last logit.
- The handshake completes on the edge where result_valid && result_ready. result_valid drops after that edge unless a new result is latched on the same edge, which is impossible for NUM_CLASSES>=2.
- result_ready while result_valid is low has no effect.
- err_seq and err_overrun are registered: high for exactly the one cycle after the offending edge.
- busy is high exactly while in COLLECT.
- Full frame throughput: NUM_CLASSES cycles plus the handshake; the handshake may overlap with element 0 of the next frame.

## Test plan
- Logits for addr 0..19, all −1.0 (0xFF000000) except addr 7=0.15625 (0x00280000) and addr 3=0.0 (0x00000000), threshold=0x00100000, ready held high -> result_valid one cycle after addr 19; class_idx=7, class_score=0x00280000, margin=0x00280000, detect=1, then IDLE.
- Equal maxima at addr 4 and addr 12 (0x01000000), others 0 -> class_idx=4, margin=0, detect=1 only when threshold<=0.
- Frame with addr 5 skipped (4 then 6) -> err_seq pulse, busy drops, no result_valid. Frame starting at addr 3 in IDLE -> err_seq pulse, stays IDLE.
- Complete frame with result_ready low, then 3 extra logits -> three err_overrun pulses, result fields and rd_data unchanged. Assert ready with addr 0 in the same cycle -> handshake plus new frame starts (busy=1).
- best=0x7FFFFFFF, second=0x80000000 -> margin saturates to 0x7FFFFFFF. rd_addr=19 returns the addr-19 logit; rd_addr=25 returns 0.
- rst asserted mid-frame (after addr 10) and again in HOLD -> every output 0 on the next cycle; the next full frame produces a correct result.
